// File: rtl/rtc_pkg.sv
// Shared widths, reset constants and a format helper for the real-time clock core.
package rtc_pkg;

    localparam int NS_W     = 38;  // ns, 30.8 fixed point
    localparam int SEC_W    = 48;  // whole seconds
    localparam int PER_W    = 40;  // period, 8.32 fixed point
    localparam int ACC_W    = 62;  // accumulator, 30.32 fixed point
    localparam int FRAC_EXT = 24;  // extra fraction bits of acc below the ns output
    localparam int ADJ_W    = 32;  // adjustment duration in clk cycles

    localparam logic [PER_W-1:0] RESET_PERIOD = 40'h08_0000_0000;  // 8 ns
    localparam logic [NS_W-1:0]  RESET_MODULO = 38'h3B_9ACA_0000;  // 1e9 ns

    // Widen a 30.8 ns value to the 30.32 accumulator format.
    function automatic logic [ACC_W-1:0] ns_to_acc(input logic [NS_W-1:0] ns);
        return {ns, {FRAC_EXT{1'b0}}};
    endfunction

endpackage

// File: rtl/rtc_timer_if.sv
// Load/read-back bus between the register block (master) and the RTC core (slave).
interface rtc_timer_if;
    import rtc_pkg::*;

    logic               rtc_rst_in;
    logic               time_ld_in;
    logic [NS_W-1:0]    time_reg_ns_in;
    logic [SEC_W-1:0]   time_reg_sec_in;
    logic               period_ld_in;
    logic [PER_W-1:0]   period_in;
    logic [NS_W-1:0]    time_acc_modulo_in;
    logic               adj_ld_in;
    logic [ADJ_W-1:0]   adj_ld_data_in;
    logic [PER_W-1:0]   period_adj_in;
    logic [NS_W-1:0]    time_reg_ns_out;
    logic [SEC_W-1:0]   time_reg_sec_out;
    logic               pps_out;

    modport master (
        output rtc_rst_in, time_ld_in, time_reg_ns_in, time_reg_sec_in,
               period_ld_in, period_in, time_acc_modulo_in,
               adj_ld_in, adj_ld_data_in, period_adj_in,
        input  time_reg_ns_out, time_reg_sec_out, pps_out
    );

    modport slave (
        input  rtc_rst_in, time_ld_in, time_reg_ns_in, time_reg_sec_in,
               period_ld_in, period_in, time_acc_modulo_in,
               adj_ld_in, adj_ld_data_in, period_adj_in,
        output time_reg_ns_out, time_reg_sec_out, pps_out
    );

endinterface

// File: rtl/rtc_adj_ctrl.sv
// Bounded-duration period override: holds the adjustment period and remaining
// cycle count, and selects which period feeds the accumulator this cycle.
module rtc_adj_ctrl
    import rtc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst_i,
    input  logic             adj_ld_i,
    input  logic [ADJ_W-1:0] adj_cnt_i,
    input  logic [PER_W-1:0] per_adj_i,
    input  logic [PER_W-1:0] per_i,
    output logic [PER_W-1:0] inc_o
);

    localparam logic [ADJ_W-1:0] ADJ_ONE = 1;

    logic [ADJ_W-1:0] adj_cnt_q, adj_cnt_d;
    logic [PER_W-1:0] per_adj_q, per_adj_d;

    // Select uses the registered count, so a reload only affects the next tick.
    assign inc_o = (adj_cnt_q != '0) ? per_adj_q : per_i;

    // Next-state: soft reset wins, then reload, else count down while active.
    always_comb begin
        adj_cnt_d = adj_cnt_q;
        per_adj_d = per_adj_q;
        if (soft_rst_i) begin
            adj_cnt_d = '0;
            per_adj_d = '0;
        end else if (adj_ld_i) begin
            adj_cnt_d = adj_cnt_i;
            per_adj_d = per_adj_i;
        end else if (adj_cnt_q != '0) begin
            adj_cnt_d = adj_cnt_q - ADJ_ONE;
        end
    end

    // Adjustment state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_cnt_q <= '0;
            per_adj_q <= '0;
        end else begin
            adj_cnt_q <= adj_cnt_d;
            per_adj_q <= per_adj_d;
        end
    end

endmodule

// File: rtl/rtc_timer.sv
// Seconds/nanoseconds time-of-day counter advancing by a fractional-ns period
// each clock, with programmable ns rollover and a period override for slewing.
// Optional: define RTC_PPS_EN to drive pps_out; otherwise pps_out is tied low.
module rtc_timer
    import rtc_pkg::*;
#(
    parameter logic [rtc_pkg::PER_W-1:0] RESET_PERIOD = rtc_pkg::RESET_PERIOD,
    parameter logic [rtc_pkg::NS_W-1:0]  RESET_MODULO = rtc_pkg::RESET_MODULO
) (
    input  logic        clk,
    input  logic        rst_n,
    rtc_timer_if.slave  bus
);

    localparam logic [SEC_W-1:0] SEC_ONE = 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [NS_W-1:0]  mod_q, mod_d;
    logic [PER_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic             rollover;

    rtc_adj_ctrl u_adj_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst_i (bus.rtc_rst_in),
        .adj_ld_i   (bus.adj_ld_in),
        .adj_cnt_i  (bus.adj_ld_data_in),
        .per_adj_i  (bus.period_adj_in),
        .per_i      (per_q),
        .inc_o      (inc)
    );

    // Single compare-and-subtract per cycle; mod==0 disables rollover entirely.
    assign sum      = acc_q + {{(ACC_W-PER_W){1'b0}}, inc};
    assign rollover = (mod_q != '0) && (sum[ACC_W-1:FRAC_EXT] >= mod_q);

    // Next-state: soft reset masks all strobes; time load replaces the tick.
    always_comb begin
        acc_d = acc_q;
        sec_d = sec_q;
        per_d = per_q;
        mod_d = mod_q;
        if (bus.rtc_rst_in) begin
            acc_d = '0;
            sec_d = '0;
            per_d = RESET_PERIOD;
            mod_d = RESET_MODULO;
        end else begin
            if (bus.time_ld_in) begin
                acc_d = ns_to_acc(bus.time_reg_ns_in);
                sec_d = bus.time_reg_sec_in;
            end else if (rollover) begin
                acc_d = sum - ns_to_acc(mod_q);
                sec_d = sec_q + SEC_ONE;
            end else begin
                acc_d = sum;
            end
            if (bus.period_ld_in) begin
                per_d = bus.period_in;
                mod_d = bus.time_acc_modulo_in;
            end
        end
    end

    // Time, period and modulo state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sec_q <= '0;
            per_q <= RESET_PERIOD;
            mod_q <= RESET_MODULO;
        end else begin
            acc_q <= acc_d;
            sec_q <= sec_d;
            per_q <= per_d;
            mod_q <= mod_d;
        end
    end

    assign bus.time_reg_ns_out  = acc_q[ACC_W-1:FRAC_EXT];
    assign bus.time_reg_sec_out = sec_q;

`ifdef RTC_PPS_EN
    logic pps_q;

    // One-cycle pulse on each ticked second rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pps_q <= 1'b0;
        end else begin
            pps_q <= !bus.rtc_rst_in && !bus.time_ld_in && rollover;
        end
    end

    assign bus.pps_out = pps_q;
`else
    assign bus.pps_out = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timer.sv
// Self-checking bench for rtc_timer: directed scenarios with hand-computed
// values plus randomized strobes checked against a time-of-day model.
module tb_rtc_timer;
    import rtc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rtc_timer_if bus ();

    rtc_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: time held as total 2^-32 ns units within the current second.
    localparam logic [63:0] ACC_MASK = (64'd1 << 62) - 64'd1;
    logic [63:0] m_t;
    logic [47:0] m_sec;
    logic [39:0] m_per;
    logic [39:0] m_adj_per;
    logic [37:0] m_mod;
    longint      m_adj_left;
    bit          m_pps;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] ns_fmt(input longint unsigned n);
        return 38'(n << 8);
    endfunction

    task automatic model_reset();
        m_t        = '0;
        m_sec      = '0;
        m_per      = 40'h08_0000_0000;
        m_mod      = ns_fmt(64'd1_000_000_000);
        m_adj_per  = '0;
        m_adj_left = 0;
        m_pps      = 1'b0;
    endtask

    // Advance the model by one clock, using the strobes present at the edge.
    task automatic model_step();
        logic [39:0] step;
        logic [63:0] t;
        logic [63:0] limit;
        if (bus.rtc_rst_in) begin
            model_reset();
            return;
        end
        step = (m_adj_left > 0) ? m_adj_per : m_per;
        if (m_adj_left > 0) m_adj_left--;
        if (bus.time_ld_in) begin
            m_t   = {2'b0, bus.time_reg_ns_in, 24'b0};
            m_sec = bus.time_reg_sec_in;
            m_pps = 1'b0;
        end else begin
            t     = (m_t + {24'b0, step}) & ACC_MASK;
            limit = {26'b0, m_mod} << 24;
            if (m_mod != 0 && t >= limit) begin
                m_t   = t - limit;
                m_sec = m_sec + 48'd1;
                m_pps = 1'b1;
            end else begin
                m_t   = t;
                m_pps = 1'b0;
            end
        end
        if (bus.period_ld_in) begin
            m_per = bus.period_in;
            m_mod = bus.time_acc_modulo_in;
        end
        if (bus.adj_ld_in) begin
            m_adj_per  = bus.period_adj_in;
            m_adj_left = longint'(bus.adj_ld_data_in);
        end
    endtask

    function automatic bit pps_exp(input bit p);
`ifdef RTC_PPS_EN
        return p;
`else
        return 1'b0 & p;
`endif
    endfunction

    task automatic cmp_model(input string tag);
        check_val({tag, "_ns"},  bus.time_reg_ns_out,  m_t[61:24]);
        check_val({tag, "_sec"}, bus.time_reg_sec_out, m_sec);
        check_val({tag, "_pps"}, bus.pps_out,          pps_exp(m_pps));
    endtask

    task automatic clear_strobes();
        bus.rtc_rst_in   = 1'b0;
        bus.time_ld_in   = 1'b0;
        bus.period_ld_in = 1'b0;
        bus.adj_ld_in    = 1'b0;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cmp_model(tag);
        clear_strobes();
    endtask

    task automatic load_time(input logic [47:0] s, input logic [37:0] ns);
        bus.time_ld_in      = 1'b1;
        bus.time_reg_sec_in = s;
        bus.time_reg_ns_in  = ns;
    endtask

    task automatic load_period(input logic [39:0] p, input logic [37:0] md);
        bus.period_ld_in       = 1'b1;
        bus.period_in          = p;
        bus.time_acc_modulo_in = md;
    endtask

    task automatic load_adj(input logic [39:0] p, input logic [31:0] n);
        bus.adj_ld_in      = 1'b1;
        bus.period_adj_in  = p;
        bus.adj_ld_data_in = n;
    endtask

    initial begin
        clear_strobes();
        bus.time_reg_ns_in     = '0;
        bus.time_reg_sec_in    = '0;
        bus.period_in          = '0;
        bus.time_acc_modulo_in = '0;
        bus.adj_ld_data_in     = '0;
        bus.period_adj_in      = '0;
        model_reset();

        // Reset state while rst_n is held low
        #2;
        check_val("rst_ns",  bus.time_reg_ns_out,  64'd0);
        check_val("rst_sec", bus.time_reg_sec_out, 64'd0);
        check_val("rst_pps", bus.pps_out,          64'd0);
        #10 rst_n = 1'b1;

        // Default period after reset: 8, 16, 24, 32 ns
        for (int k = 1; k <= 4; k++) begin
            cycle("dflt");
            check_val("dflt_ns_abs", bus.time_reg_ns_out, 64'(ns_fmt(64'(8 * k))));
            check_val("dflt_sec_abs", bus.time_reg_sec_out, 64'd0);
        end

        // Rollover into seconds
        load_time(48'd5, ns_fmt(64'd999_999_984));
        cycle("roll_ld");
        check_val("roll_ld_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd999_999_984)));
        cycle("roll_t1");
        check_val("roll_t1_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd999_999_992)));
        cycle("roll_t2");
        check_val("roll_t2_ns",  bus.time_reg_ns_out,  64'd0);
        check_val("roll_t2_sec", bus.time_reg_sec_out, 64'd6);
        check_val("roll_t2_pps", bus.pps_out,          64'(pps_exp(1'b1)));
        cycle("roll_t3");
        check_val("roll_t3_pps", bus.pps_out,         64'd0);
        check_val("roll_t3_ns",  bus.time_reg_ns_out, 64'(ns_fmt(64'd8)));

        // Adjustment: 4 ticks of 8.5 ns, then back to 8 ns
        load_time(48'd0, 38'd0);
        load_adj(40'h08_8000_0000, 32'd4);
        cycle("adj_ld");
        for (int k = 0; k < 4; k++) cycle("adj_run");
        check_val("adj_ahead_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd34)));
        cycle("adj_done");
        check_val("adj_done_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd42)));

        // Fractional period: park acc one 2^-32 ns unit below the next ns LSB
        load_time(48'd0, ns_fmt(64'd100));
        load_period(40'h00_00FF_FFFF, ns_fmt(64'd1_000_000_000));
        cycle("frac_ld");
        load_period(40'h00_0000_0001, ns_fmt(64'd1_000_000_000));
        cycle("frac_near");
        check_val("frac_near_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd100)));
        cycle("frac_cross");
        check_val("frac_cross_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd100)) + 64'd1);
        cycle("frac_hold");
        check_val("frac_hold_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd100)) + 64'd1);

        // Priority: soft reset masks simultaneous time and adjustment loads
        load_adj(40'h10_0000_0000, 32'd100);
        load_period(40'h04_0000_0000, ns_fmt(64'd500));
        cycle("prio_setup");
        bus.rtc_rst_in = 1'b1;
        load_time(48'd77, ns_fmt(64'd123));
        load_adj(40'h20_0000_0000, 32'd50);
        cycle("prio_rst");
        check_val("prio_rst_ns",  bus.time_reg_ns_out,  64'd0);
        check_val("prio_rst_sec", bus.time_reg_sec_out, 64'd0);
        cycle("prio_after");
        check_val("prio_after_ns", bus.time_reg_ns_out, 64'(ns_fmt(64'd8)));

        // Seconds wrap to zero on rollover
        load_time(48'hFFFF_FFFF_FFFF, ns_fmt(64'd999_999_992));
        cycle("wrap_ld");
        cycle("wrap_tick");
        check_val("wrap_sec", bus.time_reg_sec_out, 64'd0);
        check_val("wrap_ns",  bus.time_reg_ns_out,  64'd0);

        // Randomized strobes against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) bus.rtc_rst_in = 1'b1;
            if ($urandom_range(0, 15) == 0)
                load_time(48'($urandom_range(0, 1000)), ns_fmt(64'($urandom_range(0, 150))));
            if ($urandom_range(0, 23) == 0)
                load_period({8'($urandom_range(1, 100)), 32'($urandom)},
                            ($urandom_range(0, 7) == 0) ? 38'd0
                            : (ns_fmt(64'($urandom_range(200, 2000))) | 38'($urandom_range(0, 255))));
            if ($urandom_range(0, 15) == 0)
                load_adj({8'($urandom_range(1, 100)), 32'($urandom)}, 32'($urandom_range(0, 20)));
            cycle("rnd");
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                cmp_model("async_rst");
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
